// File: rtl/video_pkg.sv
// Shared types and constants for the video pattern generator.
// Bar colours are 3-bit {b,g,r} masks, index 0 = leftmost bar.
package video_pkg;

  typedef enum logic [1:0] {
    SOLID     = 2'd0,
    BARS      = 2'd1,
    RAMP      = 2'd2,
    RAMP_MOVE = 2'd3
  } patgen_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } patgen_state_t;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0][2:0] BAR_MASK = {
    3'b000, 3'b100, 3'b001, 3'b101,
    3'b010, 3'b110, 3'b011, 3'b111
  };

endpackage

// File: rtl/video_timing_gen.sv
// Raster counters, run/idle FSM, frame counter and raw de/hs/vs.
// Frames always complete; en_i is only looked at on frame boundaries.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [HW-1:0] h_cnt_o,
  output logic [VW-1:0] v_cnt_o,
  output logic [7:0]    frame_cnt_o,
  output logic          de_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          busy_o,
  output logic          load_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_B   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_B   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E   = VW'(V_ACTIVE + V_FP + V_SYNC);

  patgen_state_t r_state;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [7:0]    r_frame;

  logic w_run;
  logic w_h_end;
  logic w_f_end;

  assign w_run   = (r_state == RUN);
  assign w_h_end = (r_h == H_LAST);
  assign w_f_end = w_run && w_h_end && (r_v == V_LAST);

  // Frame FSM: start on en_i, wrap or stop only at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_h <= '0;
          r_v <= '0;
          if (en_i)
            r_state <= RUN;
        end
        RUN: begin
          if (w_h_end) begin
            r_h <= '0;
            if (r_v == V_LAST) begin
              r_v <= '0;
              if (en_i)
                r_frame <= r_frame + 8'd1;
              else
                r_state <= IDLE;
            end else begin
              r_v <= r_v + VW'(1);
            end
          end else begin
            r_h <= r_h + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_o = en_i && (!w_run || w_f_end);

  assign h_cnt_o     = r_h;
  assign v_cnt_o     = r_v;
  assign frame_cnt_o = r_frame;
  assign busy_o      = w_run;

  assign de_o = w_run && (r_h < H_ACT) && (r_v < V_ACT);
  assign hs_o = w_run && (r_h >= HS_B) && (r_h < HS_E);
  assign vs_o = w_run && (r_v >= VS_B) && (r_v < VS_E);

endmodule

// File: rtl/video_pattern_gen.sv
// Raster test-pattern source: timing plus solid/bars/ramp patterns.
// Optional VIDEO_PATGEN_BORDER_EN draws a full-scale white frame border.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic [1:0]               mode_i,
  input  logic [3*PIXEL_WIDTH-1:0] solid_i,
  output logic [3*PIXEL_WIDTH-1:0] do_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic                     busy_o
);

  localparam int PW  = PIXEL_WIDTH;
  localparam int HW  = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW  = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int BW  = H_ACTIVE / 8;
  localparam int BPW = $clog2(BW + 1);

  localparam logic [HW-1:0]  H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [BPW-1:0] BP_END = BPW'(BW - 1);

  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v;
  logic [7:0]    w_frame;
  logic          w_de;
  logic          w_hs;
  logic          w_vs;
  logic          w_busy;
  logic          w_load;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .h_cnt_o     (w_h),
    .v_cnt_o     (w_v),
    .frame_cnt_o (w_frame),
    .de_o        (w_de),
    .hs_o        (w_hs),
    .vs_o        (w_vs),
    .busy_o      (w_busy),
    .load_o      (w_load)
  );

  patgen_mode_t         r_mode;
  logic [3*PW-1:0]      r_solid;
  logic [2:0]           r_bar;
  logic [BPW-1:0]       r_bar_px;
  logic [3*PW-1:0]      r_do;
  logic                 r_de;
  logic                 r_hs;
  logic                 r_vs;

  // Pattern selection is frozen for the whole frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= SOLID;
      r_solid <= '0;
    end else if (w_load) begin
      r_mode  <= patgen_mode_t'(mode_i);
      r_solid <= solid_i;
    end
  end

  // Bar index tracks h_cnt; restarts at each line start
  always_ff @(posedge clk) begin
    if (rst || !w_busy || w_h == H_LAST) begin
      r_bar    <= '0;
      r_bar_px <= '0;
    end else if (r_bar_px == BP_END) begin
      r_bar    <= r_bar + 3'd1;
      r_bar_px <= '0;
    end else begin
      r_bar_px <= r_bar_px + BPW'(1);
    end
  end

  logic [31:0]     w_sum;
  logic [PW-1:0]   w_x;
  logic [PW-1:0]   w_xm;
  logic [2:0]      w_mask;
  logic [3*PW-1:0] w_pix;

  assign w_sum  = 32'(w_h) + 32'(w_frame);
  assign w_x    = PW'(32'(w_h));
  assign w_xm   = PW'(w_sum);
  assign w_mask = BAR_MASK[r_bar];

  // Pattern mux for the current raster position
  always_comb begin
    w_pix = '0;
    unique case (r_mode)
      SOLID:     w_pix = r_solid;
      BARS:      w_pix = {{PW{w_mask[2]}},
                          {PW{w_mask[1]}},
                          {PW{w_mask[0]}}};
      RAMP:      w_pix = {3{w_x}};
      RAMP_MOVE: w_pix = {3{w_xm}};
      default:   w_pix = '0;
    endcase
`ifdef VIDEO_PATGEN_BORDER_EN
    if (w_h == '0 || w_h == HW'(H_ACTIVE - 1) ||
        w_v == '0 || w_v == VW'(V_ACTIVE - 1))
      w_pix = '1;
`endif
  end

`ifndef VIDEO_PATGEN_BORDER_EN
  logic w_unused_v;
  assign w_unused_v = ^w_v;
`endif

  // Output registers, one clock behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_do <= '0;
      r_de <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
    end else begin
      r_do <= w_de ? w_pix : '0;
      r_de <= w_de;
      r_hs <= w_hs;
      r_vs <= w_vs;
    end
  end

  assign do_o   = r_do;
  assign de_o   = r_de;
  assign hs_o   = r_hs;
  assign vs_o   = r_vs;
  assign busy_o = w_busy;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen with a small raster (24x7 clocks/lines).
// Frame-position reference model plus directed test-plan checks.
module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk;
  logic        rst;
  logic        en_i;
  logic [1:0]  mode_i;
  logic [23:0] solid_i;
  logic [23:0] do_o;
  logic        de_o;
  logic        hs_o;
  logic        vs_o;
  logic        busy_o;

  video_pattern_gen #(
    .PIXEL_WIDTH (8),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .solid_i (solid_i),
    .do_o    (do_o),
    .de_o    (de_o),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00,
                            24'h00FF00, 24'hFF00FF, 24'h0000FF,
                            24'hFF0000, 24'h000000};

  // Reference model: frame position k = v*HT + h, frame index counted
  // without wrap; pattern derived directly from the pattern rules.
  logic        m_run;
  int          m_k;
  int          m_frames;
  logic [1:0]  m_mode;
  logic [23:0] m_solid;
  logic        o_run;
  int          o_k;
  int          o_frame;
  logic [23:0] e_do;
  logic        e_de, e_hs, e_vs;
  int          mh, mv;

  function automatic logic [23:0] pix(int h, int fc,
                                      logic [1:0] md, logic [23:0] sol);
    logic [7:0] a;
    case (md)
      2'd0: return sol;
      2'd1: return bars[h / (HA / 8)];
      2'd2: begin a = 8'(h); return {a, a, a}; end
      default: begin a = 8'((h + fc) % 256); return {a, a, a}; end
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_k = 0; m_frames = 0;
      m_mode = 2'd0; m_solid = '0;
      o_run = 1'b0; o_k = 0; o_frame = 0;
      e_do = '0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
    end else begin
      mh = m_k % HT;
      mv = m_k / HT;
      e_de = m_run && mh < HA && mv < VA;
      e_hs = m_run && mh >= HA + HF && mh < HA + HF + HS;
      e_vs = m_run && mv >= VA + VF && mv < VA + VF + VS;
      e_do = e_de ? pix(mh, m_frames % 256, m_mode, m_solid) : '0;
`ifdef VIDEO_PATGEN_BORDER_EN
      if (e_de && (mh == 0 || mh == HA - 1 || mv == 0 || mv == VA - 1))
        e_do = 24'hFFFFFF;
`endif
      o_run = m_run; o_k = m_k; o_frame = m_frames;
      if (!m_run) begin
        if (en_i) begin
          m_run = 1'b1; m_k = 0;
          m_mode = mode_i; m_solid = solid_i;
        end
      end else if (m_k == FT - 1) begin
        m_k = 0;
        if (en_i) begin
          m_frames++;
          m_mode = mode_i; m_solid = solid_i;
        end else begin
          m_run = 1'b0;
        end
      end else begin
        m_k++;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("do",   32'(do_o),   32'(e_do));
    chk("de",   32'(de_o),   32'(e_de));
    chk("hs",   32'(hs_o),   32'(e_hs));
    chk("vs",   32'(vs_o),   32'(e_vs));
    chk("busy", 32'(busy_o), 32'(m_run));
  endtask

  task automatic wait_pos(int fr, int k, int budget);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!(o_run && o_frame == fr && o_k == k) && n < budget);
    chk("wait_pos_timeout", 32'(n >= budget && !(o_run && o_k == k)), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int dec, pxok, vsc, hsc, hs1, nb;
    rst = 1'b1; en_i = 1'b0; mode_i = 2'd0; solid_i = '0;
    repeat (3) cyc();
    chk("rst_do",   32'(do_o),   32'd0);
    chk("rst_de",   32'(de_o),   32'd0);
    chk("rst_hs",   32'(hs_o),   32'd0);
    chk("rst_vs",   32'(vs_o),   32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // 1: solid frame, timing counts
    rst = 1'b0; en_i = 1'b1; mode_i = 2'd0; solid_i = 24'h102030;
    cyc();
    chk("lat1_de", 32'(de_o), 32'd0);
    cyc();
    chk("lat2_de", 32'(de_o), 32'd1);
    dec = 0; pxok = 0; vsc = 0; hsc = 0; hs1 = -1;
    for (int i = 0; i < FT; i++) begin
      if (i > 0) cyc();
      if (de_o) dec++;
      if (de_o && do_o == 24'h102030) pxok++;
      if (vs_o) vsc++;
      if (hs_o) begin hsc++; if (hs1 < 0) hs1 = i; end
    end
    cyc();
    chk("t1_de_cnt", 32'(dec), 32'd64);
    chk("t1_px_ok",  32'(pxok), 32'd64);
    chk("t1_vs_cnt", 32'(vsc), 32'd24);
    chk("t1_hs_cnt", 32'(hsc), 32'd21);
    chk("t1_hs_off", 32'(hs1), 32'd18);
    chk("t1_period", 32'(de_o), 32'd1);

    // 2: colour bars on one active line
    do_reset();
    en_i = 1'b1; mode_i = 2'd1;
    for (int x = 0; x < HA; x++) begin
      wait_pos(0, HT + x, 400);
      chk("t2_bar", 32'(do_o), 32'(bars[x / 2]));
    end
    wait_pos(0, HT + HA + 1, 400);
    chk("t2_blank", 32'(do_o), 32'd0);

    // 3/4: moving ramp, frame counter wrap
    do_reset();
    en_i = 1'b1; mode_i = 2'd3;
    wait_pos(0, 5, 400);
    chk("t3_f0", 32'(do_o), 32'h050505);
    wait_pos(1, 5, 400);
    chk("t3_f1", 32'(do_o), 32'h060606);
    wait_pos(2, 5, 400);
    chk("t3_f2", 32'(do_o), 32'h070707);
    wait_pos(256, 0, 260 * FT);
    chk("t4_wrap", 32'(do_o), 32'h000000);
    wait_pos(299, 0, 50 * FT);
    chk("t4_f299", 32'(do_o), 32'h2B2B2B);

    // 5a: drop en mid-frame, frame completes
    do_reset();
    en_i = 1'b1; mode_i = 2'd0; solid_i = 24'h0A0B0C;
    nb = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (i == 20) en_i = 1'b0;
      if (busy_o) nb++;
      else if (nb > 0) break;
    end
    chk("t5_busy_len", 32'(nb), 32'(FT));
    repeat (30) cyc();
    chk("t5_idle_de", 32'(de_o), 32'd0);

    // 5b: mode change mid-frame
    en_i = 1'b1;
    wait_pos(m_frames, HT + 3, 400);
    chk("t5_old", 32'(do_o), 32'h0A0B0C);
    mode_i = 2'd2;
    wait_pos(o_frame, 2 * HT + 3, 400);
    chk("t5_still", 32'(do_o), 32'h0A0B0C);
    wait_pos(o_frame + 1, 0, 400);
    chk("t5_new0", 32'(do_o), 32'h000000);
    wait_pos(o_frame, 3, 400);
    chk("t5_new3", 32'(do_o), 32'h030303);

    // 6: reset mid-frame at line 2, x=7
    do_reset();
    en_i = 1'b1; mode_i = 2'd0; solid_i = 24'h445566;
    for (int i = 0; i < 400; i++) begin
      if (m_run && m_k == 2 * HT + 7) break;
      cyc();
    end
    rst = 1'b1;
    cyc();
    chk("t6_do",   32'(do_o),   32'd0);
    chk("t6_de",   32'(de_o),   32'd0);
    chk("t6_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    cyc();
    chk("t6_lat1", 32'(de_o), 32'd0);
    cyc();
    chk("t6_de0",  32'(de_o), 32'd1);
    chk("t6_px0",  32'(do_o), 32'h445566);

    // Random: mode/colour/en/reset churn against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) mode_i = 2'($urandom);
      if ($urandom_range(0, 49) == 0) solid_i = 24'($urandom);
      if ($urandom_range(0, 299) == 0) en_i = ~en_i;
      rst = ($urandom_range(0, 1499) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
